center_divider: RTL and testbench

//  Back end of the colour-tracking path. Accepts the per-frame sums from the

---
 rtl/com_pkg.sv | 21 ++
 rtl/serial_div_core.sv | 78 +++++++
 rtl/center_divider.sv | 190 +++++++++++++++++++
 tb/tb_center_divider.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/com_pkg.sv
// ---------------------------------------------------------------------------
// com_pkg
// Shared definitions for the colour-tracking centroid back end.
//   COM_NUM_W    : width of the x/y weighted sums (numerators)
//   COM_DEN_W    : width of the hit count (shared denominator)
//   COM_OUT_W    : width of the centre coordinates
//   cdiv_state_t : control states of center_divider
// ---------------------------------------------------------------------------
package com_pkg;

  localparam int COM_NUM_W = 29;
  localparam int COM_DEN_W = 20;
  localparam int COM_OUT_W = 10;

  typedef enum logic [1:0] {
    CDIV_IDLE   = 2'd0,
    CDIV_DIVIDE = 2'd1,
    CDIV_DONE   = 2'd2
  } cdiv_state_t;

endpackage : com_pkg

// File: rtl/serial_div_core.sv
// ---------------------------------------------------------------------------
// serial_div_core
// Serial restoring divider producing one quotient bit per 'step'.
// Ports:
//   clk      in  1      system clock
//   reset    in  1      asynchronous active-low reset
//   load     in  1      capture num_in/den_in, clear remainder and quotient
//   step     in  1      perform one restoring iteration
//   num_in   in  NUM_W  dividend
//   den_in   in  DEN_W  divisor
//   quotient out NUM_W  quotient shift register (final after NUM_W steps)
// ---------------------------------------------------------------------------
module serial_div_core
  import com_pkg::*;
#(
  parameter int NUM_W = COM_NUM_W,
  parameter int DEN_W = COM_DEN_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [NUM_W-1:0] num_in,
  input  logic [DEN_W-1:0] den_in,
  output logic [NUM_W-1:0] quotient
);

  logic [NUM_W-1:0] num_r;
  logic [DEN_W-1:0] den_r;
  logic [DEN_W:0]   rem_r;
  logic [NUM_W-1:0] quo_r;

  logic [DEN_W:0]   rem_shift_s;
  logic [DEN_W:0]   rem_next_s;
  logic             qbit_s;

  // One restoring iteration: bring in the next dividend bit, subtract if it fits.
  // The remainder is always < divisor, so its top bit is free to take the shift.
  always_comb begin
    rem_shift_s = {rem_r[DEN_W-1:0], num_r[NUM_W-1]};
    rem_next_s  = rem_shift_s;
    qbit_s      = 1'b0;
    if (rem_shift_s >= {1'b0, den_r}) begin
      rem_next_s = rem_shift_s - {1'b0, den_r};
      qbit_s     = 1'b1;
    end else begin
      rem_next_s = rem_shift_s;
      qbit_s     = 1'b0;
    end
  end

  // Operand capture and shift-register update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      num_r <= '0;
      den_r <= '0;
      rem_r <= '0;
      quo_r <= '0;
    end else if (load) begin
      num_r <= num_in;
      den_r <= den_in;
      rem_r <= '0;
      quo_r <= '0;
    end else if (step) begin
      num_r <= {num_r[NUM_W-2:0], 1'b0};
      rem_r <= rem_next_s;
      quo_r <= {quo_r[NUM_W-2:0], qbit_s};
    end else begin
      num_r <= num_r;
      den_r <= den_r;
      rem_r <= rem_r;
      quo_r <= quo_r;
    end
  end

  assign quotient = quo_r;

endmodule : serial_div_core

// File: rtl/center_divider.sv
// ---------------------------------------------------------------------------
// center_divider
// Computes the per-frame centroid x_sum/count and y_sum/count using two
// parallel serial restoring dividers. Results are held until the next frame.
// Ports:
//   clk       in  1      system clock
//   reset     in  1      asynchronous active-low reset
//   start     in  1      one-cycle request, operands valid in the same cycle
//   x_sum     in  NUM_W  sum of x over included pixels
//   y_sum     in  NUM_W  sum of y over included pixels
//   count     in  DEN_W  number of included pixels
//   busy      out 1      high while a request is in flight (start ignored)
//   done      out 1      one-cycle pulse when results are updated
//   valid     out 1      last result came from a non-zero count
//   x_center  out OUT_W  saturated x quotient
//   y_center  out OUT_W  saturated y quotient
// Timing: with start sampled at edge E0, done is high after edge E0+NUM_W+1
// for a non-zero count, and after edge E0+1 for a zero count.
// ---------------------------------------------------------------------------
module center_divider
  import com_pkg::*;
#(
  parameter int NUM_W = COM_NUM_W,
  parameter int DEN_W = COM_DEN_W,
  parameter int OUT_W = COM_OUT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [NUM_W-1:0] x_sum,
  input  logic [NUM_W-1:0] y_sum,
  input  logic [DEN_W-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             valid,
  output logic [OUT_W-1:0] x_center,
  output logic [OUT_W-1:0] y_center
);

  localparam int CNT_W = $clog2(NUM_W);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(NUM_W - 1);

  // Clamp a full-width quotient to the largest screen coordinate.
  function automatic logic [OUT_W-1:0] sat_center(input logic [NUM_W-1:0] q);
    if (|q[NUM_W-1:OUT_W]) begin
      return {OUT_W{1'b1}};
    end else begin
      return q[OUT_W-1:0];
    end
  endfunction

  cdiv_state_t      state_r;
  cdiv_state_t      next_s;
  logic [CNT_W-1:0] cnt_r;
  logic             zero_r;
  logic             fin_r;
  logic             load_s;
  logic             step_s;

  logic             busy_r;
  logic             done_r;
  logic             valid_r;
  logic [OUT_W-1:0] x_center_r;
  logic [OUT_W-1:0] y_center_r;

  logic [NUM_W-1:0] x_quo_s;
  logic [NUM_W-1:0] y_quo_s;

  serial_div_core #(
    .NUM_W (NUM_W),
    .DEN_W (DEN_W)
  ) u_x_div (
    .clk      (clk),
    .reset    (reset),
    .load     (load_s),
    .step     (step_s),
    .num_in   (x_sum),
    .den_in   (count),
    .quotient (x_quo_s)
  );

  serial_div_core #(
    .NUM_W (NUM_W),
    .DEN_W (DEN_W)
  ) u_y_div (
    .clk      (clk),
    .reset    (reset),
    .load     (load_s),
    .step     (step_s),
    .num_in   (y_sum),
    .den_in   (count),
    .quotient (y_quo_s)
  );

  // Next-state and datapath strobes.
  // DIVIDE issues NUM_W steps, then spends one more cycle so the final quotient
  // bit is settled before it is registered on the edge into DONE. A zero count
  // passes through DIVIDE for a single cycle without stepping.
  always_comb begin
    next_s = state_r;
    load_s = 1'b0;
    step_s = 1'b0;
    case (state_r)
      CDIV_IDLE: begin
        if (start) begin
          load_s = 1'b1;
          next_s = CDIV_DIVIDE;
        end else begin
          next_s = CDIV_IDLE;
        end
      end
      CDIV_DIVIDE: begin
        if (zero_r || fin_r) begin
          next_s = CDIV_DONE;
        end else begin
          step_s = 1'b1;
          next_s = CDIV_DIVIDE;
        end
      end
      CDIV_DONE: begin
        next_s = CDIV_IDLE;
      end
      default: begin
        next_s = CDIV_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= CDIV_IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Bit counter, zero flag and end-of-iterations flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r  <= '0;
      zero_r <= 1'b0;
      fin_r  <= 1'b0;
    end else if (load_s) begin
      cnt_r  <= CNT_LOAD;
      zero_r <= (count == {DEN_W{1'b0}});
      fin_r  <= 1'b0;
    end else if (step_s) begin
      if (cnt_r == {CNT_W{1'b0}}) begin
        fin_r <= 1'b1;
      end else begin
        cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      cnt_r  <= cnt_r;
      zero_r <= zero_r;
      fin_r  <= fin_r;
    end
  end

  // Registered outputs; results update on the edge that enters DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      valid_r    <= 1'b0;
      x_center_r <= '0;
      y_center_r <= '0;
    end else begin
      busy_r <= (next_s != CDIV_IDLE);
      done_r <= (next_s == CDIV_DONE);
      if ((state_r == CDIV_DIVIDE) && (next_s == CDIV_DONE)) begin
        if (zero_r) begin
          valid_r <= 1'b0;
        end else begin
          valid_r    <= 1'b1;
          x_center_r <= sat_center(x_quo_s);
          y_center_r <= sat_center(y_quo_s);
        end
      end
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign valid    = valid_r;
  assign x_center = x_center_r;
  assign y_center = y_center_r;

endmodule : center_divider

// File: tb/tb_center_divider.sv
module tb_center_divider;

  localparam int NUM_W = 29;
  localparam int DEN_W = 20;
  localparam int OUT_W = 10;

  logic             clk;
  logic             reset;
  logic             start;
  logic [NUM_W-1:0] x_sum;
  logic [NUM_W-1:0] y_sum;
  logic [DEN_W-1:0] count;
  logic             busy;
  logic             done;
  logic             valid;
  logic [OUT_W-1:0] x_center;
  logic [OUT_W-1:0] y_center;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state: what the outputs should currently hold
  longint m_x = 0;
  longint m_y = 0;
  longint m_valid = 0;

  center_divider dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .x_sum    (x_sum),
    .y_sum    (y_sum),
    .count    (count),
    .busy     (busy),
    .done     (done),
    .valid    (valid),
    .x_center (x_center),
    .y_center (y_center)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // integer centroid with clamp to the screen range
  function automatic longint ref_center(input longint num, input longint den);
    longint q;
    q = num / den;
    return (q > 1023) ? 1023 : q;
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ".valid"}, {63'd0, valid}, m_valid);
    check({tag, ".x"}, {54'd0, x_center}, m_x);
    check({tag, ".y"}, {54'd0, y_center}, m_y);
  endtask

  // Apply one request, wait for done, check latency and results.
  task automatic do_req(input longint x, input longint y, input longint c, input string tag);
    int n;
    x_sum = x[NUM_W-1:0];
    y_sum = y[NUM_W-1:0];
    count = c[DEN_W-1:0];
    start = 1'b1;
    tick();
    start = 1'b0;
    x_sum = NUM_W'($urandom);
    y_sum = NUM_W'($urandom);
    count = DEN_W'($urandom);
    check({tag, ".busy"}, {63'd0, busy}, 64'd1);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check({tag, ".latency"}, 64'(n), (c == 0) ? 64'd1 : 64'd30);
    if (c != 0) begin
      m_x = ref_center(x, c);
      m_y = ref_center(y, c);
      m_valid = 1;
    end else begin
      m_valid = 0;
    end
    check_outputs(tag);
    tick();
    check({tag, ".done_low"}, {63'd0, done}, 64'd0);
    check({tag, ".idle"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    int n;
    logic seen_done;
    longint rx, ry, rc;

    start = 1'b0;
    x_sum = '0;
    y_sum = '0;
    count = '0;
    reset = 1'b0;

    // 1: reset state
    repeat (3) tick();
    check("rst.busy", {63'd0, busy}, 64'd0);
    check("rst.done", {63'd0, done}, 64'd0);
    check_outputs("rst");
    reset = 1'b1;
    repeat (4) tick();
    check("rst_rel.busy", {63'd0, busy}, 64'd0);
    check("rst_rel.done", {63'd0, done}, 64'd0);
    check_outputs("rst_rel");

    // 2: basic request
    do_req(3200, 2400, 10, "basic");
    // 3: zero count holds previous centres
    do_req(12345, 678, 0, "zero");
    // 4: saturation and truncation
    do_req((64'd1 << 29) - 1, 7, 1, "sat");
    do_req(7, 5, 2, "trunc");
    do_req(1023, 1024, 1, "edge1023");
    do_req(0, 10239, 10, "lowzero");

    // 5: starts while busy are dropped
    x_sum = 29'd5000;
    y_sum = 29'd1000;
    count = 20'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    x_sum = 29'd999;
    y_sum = 29'd111;
    count = 20'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 6;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("drop.latency", 64'(n), 64'd30);
    m_x = ref_center(5000, 5);
    m_y = ref_center(1000, 5);
    m_valid = 1;
    check_outputs("drop");
    x_sum = 29'd777;
    y_sum = 29'd333;
    count = 20'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("drop_done.busy", {63'd0, busy}, 64'd0);
    tick();
    check("drop_done.done", {63'd0, done}, 64'd0);
    check_outputs("drop_done");
    // one cycle after done is accepted (issue right after the done cycle)
    x_sum = 29'd640;
    y_sum = 29'd480;
    count = 20'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("after_done.busy", {63'd0, busy}, 64'd1);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("after_done.latency", 64'(n), 64'd30);
    m_x = 320;
    m_y = 240;
    check_outputs("after_done");
    tick();

    // 6: reset mid-divide abandons the request
    x_sum = 29'd9000;
    y_sum = 29'd3000;
    count = 20'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 11; i++) begin
      tick();
      if (done === 1'b1) seen_done = 1'b1;
    end
    #2;
    reset = 1'b0;
    #1;
    m_x = 0;
    m_y = 0;
    m_valid = 0;
    check("midrst.busy", {63'd0, busy}, 64'd0);
    check("midrst.done", {63'd0, done}, 64'd0);
    check_outputs("midrst");
    for (int i = 0; i < 25; i++) begin
      tick();
      if (done === 1'b1) seen_done = 1'b1;
    end
    reset = 1'b1;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (done === 1'b1) seen_done = 1'b1;
    end
    check("midrst.no_done", {63'd0, seen_done}, 64'd0);
    check_outputs("midrst_hold");
    do_req(3200, 2400, 10, "post_rst");

    // randomized requests against the arithmetic model
    for (int k = 0; k < 30; k++) begin
      case ($urandom_range(0, 3))
        0: rc = 0;
        1: rc = $urandom_range(1, 16);
        2: rc = $urandom_range(1, 4095);
        default: rc = $urandom_range(1, (1 << 20) - 1);
      endcase
      if ($urandom_range(0, 1) == 1 && rc != 0) begin
        rx = rc * $urandom_range(0, 1100) + $urandom_range(0, 3);
        ry = rc * $urandom_range(0, 1100) + $urandom_range(0, 3);
        rx = rx & ((64'd1 << 29) - 1);
        ry = ry & ((64'd1 << 29) - 1);
      end else begin
        rx = longint'($urandom) & ((64'd1 << 29) - 1);
        ry = longint'($urandom) & ((64'd1 << 29) - 1);
      end
      do_req(rx, ry, rc, $sformatf("rand%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_center_divider
